serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/serial_subtractor_sub_digit.sv | 31 +++
 rtl/serial_subtractor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor.
//   state_t   : controller states (IDLE, RUN, DONE)
//   cnt_width : width of the step counter for N digit steps (minimum 1 bit)
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// One DIGIT-bit slice of the subtractor: a ripple of full-subtractor cells.
// Purely combinational.
//   x, y : minuend / subtrahend slice
//   bin  : borrow into the least significant cell
//   d    : difference slice
//   bout : borrow out of the most significant cell
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] br;

  always_comb begin
    br    = '0;
    d     = '0;
    br[0] = bin;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]    = x[i] ^ y[i] ^ br[i];
      // Borrow when x < y, or when x == y and a borrow is already pending.
      br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end
    bout = br[DIGIT];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes a - b - bin over N = WIDTH/DIGIT cycles,
// one DIGIT-bit slice per cycle, LSB slice first.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   start     : begin a subtraction (taken in IDLE or DONE, ignored in RUN)
//   a, b, bin : minuend, subtrahend, borrow-in (captured on start)
//   busy      : high while in RUN
//   done      : one-cycle pulse, result valid
//   diff      : a - b - bin modulo 2^WIDTH
//   bout      : unsigned borrow-out (a < b + bin)
//   ovf       : two's-complement overflow of a - b - bin
//   fsm_state : controller state, for observation only
//
// Handshake: start is a request with no back-pressure; it is accepted on any
// rising edge where the controller is in IDLE or DONE and rst is low. Exactly
// N edges later done pulses for one cycle and diff/bout/ovf hold the result
// until the next result load (or reset).
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic [1:0]       fsm_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1) begin : g_width_chk
    $fatal(1, "serial_subtractor: WIDTH must be at least 1");
  end
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_digit_chk
    $fatal(1, "serial_subtractor: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra;        // remaining minuend slices, shifted right each step
  logic [WIDTH-1:0] rb;        // remaining subtrahend slices
  logic [WIDTH-1:0] acc;       // partial difference, filled from the top
  logic             brw;       // borrow carried between slices
  logic             a_msb;     // operand sign bits kept for the overflow test
  logic             b_msb;

  logic [DIGIT-1:0] ds;
  logic             bo;
  logic [WIDTH-1:0] acc_next;

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x    (ra[DIGIT-1:0]),
    .y    (rb[DIGIT-1:0]),
    .bin  (brw),
    .d    (ds),
    .bout (bo)
  );

  // New slice enters at the top; after N steps the first slice sits at the LSB.
  always_comb begin
    acc_next = (acc >> DIGIT) | (WIDTH'(ds) << (WIDTH - DIGIT));
  end

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      brw   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            brw   <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          ra  <= ra >> DIGIT;
          rb  <= rb >> DIGIT;
          acc <= acc_next;
          brw <= bo;
          if (cnt == LAST) begin
            cnt   <= '0;
            diff  <= acc_next;
            bout  <= bo;
            ovf   <= (a_msb != b_msb) && (acc_next[WIDTH-1] != a_msb);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
